// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage. Owns the PC, issues one word request at a
// time to instruction memory, and holds each returned instruction until
// decode takes it. A redirect flushes whatever is in flight and restarts
// fetch at the new PC.
//
// state | meaning
// ------+-------------------------------------------------------------
// REQ   | request for pc presented to memory, waiting for acceptance
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction captured, presented to decode until consumed
// DROP  | a redirect made the outstanding response stale; discard it
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;

  // Outputs come straight from registered state; reset gates the valids so
  // nothing is offered while rst is held.
  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == S_HOLD) && !rst;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign opcode         = instr_q[6:0];

  // Fetch sequencer: redirect overrides the normal request/response flow in
  // every state, and a response owed to a flushed request is absorbed in DROP.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC & ~32'h3;
      state      <= S_REQ;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~32'h3;
      case (state)
        S_REQ:   if (imem_req_ready) state <= S_DROP;
        S_WAIT:  state <= imem_resp_valid ? S_REQ : S_DROP;
        S_HOLD:  state <= S_REQ;
        S_DROP:  if (imem_resp_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            instr_pc_q <= pc;
            pc         <= pc + 32'd4;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            instr_q <= imem_resp_data;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) state <= S_REQ;
        end
        S_DROP: begin
          if (imem_resp_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order fetch, decode stall, redirects in
// WAIT/HOLD/REQ, PC wraparound and reset in WAIT and HOLD.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;

  int vectors = 0;
  int errors  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .opcode          (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full REQ -> WAIT -> HOLD -> REQ round trip with 1-cycle memory and
  // ready decode; expects to start and end in REQ.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    check("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    tick();
    imem_resp_valid = 1'b0;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, data);
    check("instr_pc", instr_pc, addr);
    check("opcode", {25'd0, opcode}, {25'd0, data[6:0]});
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("after_hs_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    instr_ready     = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // in-order fetch from RESET_PC
    fetch_one(32'h0000_0100, 32'h00a0_0093);
    fetch_one(32'h0000_0104, 32'h0020_8133);
    fetch_one(32'h0000_0108, 32'h0000_006f);

    // spurious response in REQ is ignored
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hbad0_0bad;
    tick();
    imem_resp_valid = 1'b0;
    check("spur_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("spur_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("spur_addr", imem_req_addr, 32'h0000_010c);

    // decode stall in HOLD for 5 cycles
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hfe01_0113;
    tick();
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr, 32'hfe01_0113);
      check("stall_pc", instr_pc, 32'h0000_010c);
      check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
    end
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("stall_one_hs", {31'd0, instr_valid}, 32'd0);
    check("stall_next_req", {31'd0, imem_req_valid}, 32'd1);
    check("stall_next_addr", imem_req_addr, 32'h0000_0110);

    // redirect in WAIT, stale response arrives 3 cycles later
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    check("drop_no_req", {31'd0, imem_req_valid}, 32'd0);
    check("drop_no_instr", {31'd0, instr_valid}, 32'd0);
    tick();
    check("drop_no_instr2", {31'd0, instr_valid}, 32'd0);
    tick();
    check("drop_no_instr3", {31'd0, instr_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdead_beef;
    tick();
    imem_resp_valid = 1'b0;
    check("drop_discard", {31'd0, instr_valid}, 32'd0);
    check("redir_wait_req", {31'd0, imem_req_valid}, 32'd1);
    check("redir_wait_addr", imem_req_addr, 32'h0000_2000);
    fetch_one(32'h0000_2000, 32'h0000_0537);

    // redirect in HOLD with same-cycle instr_ready, misaligned target
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0040_0513;
    tick();
    imem_resp_valid = 1'b0;
    check("hold_pre_redir", {31'd0, instr_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3002;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    check("redir_hold_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_hold_req", {31'd0, imem_req_valid}, 32'd1);
    check("redir_hold_addr", imem_req_addr, 32'h0000_3000);
    fetch_one(32'h0000_3000, 32'h0000_0013);

    // PC wraparound, reached through a redirect while REQ is unaccepted
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffc;
    tick();
    redirect_valid = 1'b0;
    check("redir_req_addr", imem_req_addr, 32'hffff_fffc);
    fetch_one(32'hffff_fffc, 32'h0000_0063);
    check("wrap_addr", imem_req_addr, 32'h0000_0000);

    // redirect in REQ while the request fires -> response dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    check("redir_fire_drop", {31'd0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0;
    check("redir_fire_instr", {31'd0, instr_valid}, 32'd0);
    check("redir_fire_addr", imem_req_addr, 32'h0000_4000);

    // reset while in WAIT
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_wait_req", {31'd0, imem_req_valid}, 32'd0);
    check("rst_wait_instr", {31'd0, instr_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_wait_restart", imem_req_addr, 32'h0000_0100);
    check("rst_wait_req_up", {31'd0, imem_req_valid}, 32'd1);

    // reset while in HOLD
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0073;
    tick();
    imem_resp_valid = 1'b0;
    check("pre_rst_hold", {31'd0, instr_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_hold_req", {31'd0, imem_req_valid}, 32'd0);
    check("rst_hold_instr", {31'd0, instr_valid}, 32'd0);
    check("rst_hold_data", instr, 32'h0);
    rst = 1'b0;
    #1;
    fetch_one(32'h0000_0100, 32'h0010_0073);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
